// File: rtl/mux_sched_pkg.sv
// ---------------------------------------------------------------------------
// mux_sched_pkg
// Shared definitions for the round-robin mux scheduler:
//   SEL_IDLE - select value that parks the mux (mux outputs 0)
//   BURST_W  - width of the per-grant beat counter
//   state_t  - scheduler FSM states
// ---------------------------------------------------------------------------
package mux_sched_pkg;

    localparam logic [4:0] SEL_IDLE = 5'b11111;
    localparam int         BURST_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder.
// Ports:
//   req [N_REQ]  in   request vector
//   ptr [SEL_W]  in   index with highest priority this round
//   any          out  at least one request is set
//   idx [SEL_W]  out  first requesting index at or above ptr, wrapping to 0
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 31,
    parameter int SEL_W = 5
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_masked;
    logic               w_found;
    int unsigned        w_pos;

    // The request vector is duplicated; the lower copy is masked below ptr,
    // so the lowest set bit of the result is the wrapped winner.
    always_comb begin
        w_dbl = {req, req};
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            w_masked[i] = w_dbl[i] & (i >= 32'(ptr));
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pos   = 0;
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            if (!w_found && w_masked[i]) begin
                w_found = 1'b1;
                w_pos   = i;
            end
        end
    end

    always_comb begin
        any = |req;
        if (w_pos >= N_REQ) begin
            idx = SEL_W'(w_pos - N_REQ);
        end else begin
            idx = SEL_W'(w_pos);
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler
// Round-robin scheduler driving the select of a shared N_REQ:1 mux and
// presenting the muxed data under a valid/ready handshake. One requester is
// granted at a time for up to BURST accepted beats.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req        in   per-requester level request
//   out_ready  in   downstream accepts current beat
//   sel        out  registered mux select (SEL_IDLE when idle)
//   out_valid  out  muxed data valid
//   gnt        out  registered one-hot grant
//   ack        out  one-hot beat acceptance (gnt when out_valid & out_ready)
//   busy       out  high in GRANT state
// ---------------------------------------------------------------------------
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N_REQ = 31,
    parameter int SEL_W = 5,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);

    localparam logic [SEL_W-1:0]   L_SEL_IDLE = SEL_W'(SEL_IDLE);
    localparam logic [SEL_W-1:0]   L_SEL_LAST = SEL_W'(N_REQ - 1);
    localparam logic [BURST_W-1:0] L_BEAT_END = BURST_W'(BURST - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_valid;
    logic [SEL_W-1:0]   r_ptr;
    logic [BURST_W-1:0] r_beat;

    logic               w_any;
    logic [SEL_W-1:0]   w_idx;
    logic               w_xfer;
    logic               w_req_sel;
    logic               w_release;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // r_valid is only ever set in GRANT, so xfer and ack are implicitly
    // qualified by the state.
    always_comb begin
        w_xfer    = r_valid & out_ready;
        w_req_sel = |(req & r_gnt);
        w_release = (r_state == GRANT) &&
                    ((w_xfer && (r_beat == L_BEAT_END)) || !w_req_sel);
        ack       = w_xfer ? r_gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= L_SEL_IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_sel   <= w_idx;
                        r_gnt   <= N_REQ'(1) << w_idx;
                        r_valid <= 1'b1;
                        r_beat  <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_ptr   <= (r_sel == L_SEL_LAST) ? '0 : r_sel + SEL_W'(1);
                        r_sel   <= L_SEL_IDLE;
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_beat  <= '0;
                    end else if (w_xfer) begin
                        r_beat  <= r_beat + BURST_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sel       = r_sel;
    assign out_valid = r_valid;
    assign gnt       = r_gnt;
    assign busy      = (r_state == GRANT);

endmodule
